// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and
// default sizing.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full-adder cell; the only arithmetic in the serial adder datapath.
module serial_adder_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock through one full-adder cell.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' port that turns the operation into a-b.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ofl
);

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic [CNT_W-1:0] cnt;
  logic             cy;
  logic             fa_s, fa_co;
  logic             accept, last;
  logic [WIDTH-1:0] b_ld;
  logic             cy_ld;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction as a + ~b + 1; c_out then reads as not-borrow.
  assign b_ld  = sub ? ~b : b;
  assign cy_ld = sub ? 1'b1 : c_in;
`else
  assign b_ld  = b;
  assign cy_ld = c_in;
`endif

  serial_adder_fa u_fa (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .ci (cy),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      cy    <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
      ofl   <= 1'b0;
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b_ld;
      r_sr <= '0;
      cy   <= cy_ld;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      r_sr <= {fa_s, r_sr[WIDTH-1:1]};
      cy   <= fa_co;
      cnt  <= cnt + CNT_W'(1);
      // cy still holds the carry into the MSB on the final bit.
      if (last) begin
        sum   <= {fa_s, r_sr[WIDTH-1:1]};
        c_out <= fa_co;
        ofl   <= cy ^ fa_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed table plus corner-case sequences and a random regression for serial_adder.
module tb_serial_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, start, c_in, sub_i;
  logic [W-1:0] a, b;
  logic         busy, done, c_out, ofl;
  logic [W-1:0] sum;

  int n_cmp = 0;
  int n_bad = 0;
  logic busy_e1;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W), .CNT_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub_i),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .ofl   (ofl)
  );

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic [W-1:0] s;
    logic         co, ov;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Issue a start, optionally re-pulse start with junk operands at edge 'glitch',
  // and return the edge count (including the accepting edge) until done is seen.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc, input logic ts, input int glitch, output int lat);
    a = ta; b = tb_; c_in = tc; sub_i = ts; start = 1'b1;
    lat = 0;
    while (!(lat > 0 && done) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) busy_e1 = busy;
      start = (lat == glitch);
      if (lat == glitch) begin a = '1; b = '1; c_in = 1'b1; sub_i = 1'b0; end
    end
    start = 1'b0;
  endtask

  initial begin
    vec_t vecs[$];
    int lat, ndone;
    logic [W:0]   full;
    logic [W-1:0] ra, rb, bb;
    logic         rc, rs, rov;

    vecs.push_back('{16'h0001, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
    vecs.push_back('{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0});
    vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
    vecs.push_back('{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0});
    vecs.push_back('{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0});
    vecs.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1});
`endif

    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0; sub_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset sum", sum, 0);
    check("reset c_out", c_out, 0);
    check("reset ofl", ofl, 0);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, -1, lat);
      check($sformatf("vec%0d latency", i), lat, W + 1);
      check($sformatf("vec%0d busy", i), busy_e1, 1);
      check($sformatf("vec%0d sum", i), sum, vecs[i].s);
      check($sformatf("vec%0d c_out", i), c_out, vecs[i].co);
      check($sformatf("vec%0d ofl", i), ofl, vecs[i].ov);
    end

    // Back-to-back: start in the DONE cycle, no IDLE gap expected.
    run_op(16'h0001, 16'h0002, 1'b0, 1'b0, -1, lat);
    check("b2b first sum", sum, 16'h0003);
    run_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, -1, lat);
    check("b2b busy after accept", busy_e1, 1);
    check("b2b latency", lat, W + 1);
    check("b2b second sum", sum, 16'h0000);
    check("b2b second c_out", c_out, 1);

    // Start mid-RUN with new operands must be ignored.
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0, 5, lat);
    check("ignored start latency", lat, W + 1);
    check("ignored start sum", sum, 16'h5556);
    check("ignored start c_out", c_out, 0);
    @(posedge clk); #1;
    check("ignored start back to idle", {busy, done}, 2'b00);

    // Reset at RUN bit 7 aborts: outputs clear, no done follows.
    a = 16'h00FF; b = 16'h0F0F; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort sum", sum, 0);
    ndone = 0;
    repeat (25) begin @(posedge clk); #1; if (done) ndone++; end
    check("abort no done", ndone, 0);
    run_op(16'h00FF, 16'h0F0F, 1'b0, 1'b0, -1, lat);
    check("after abort latency", lat, W + 1);
    check("after abort sum", sum, 16'h100E);

    // rst has priority over a simultaneous start.
    a = 16'h1111; b = 16'h2222; start = 1'b1; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; start = 1'b0;
    check("rst beats start busy", busy, 0);
    check("rst beats start sum", sum, 0);

    for (int k = 0; k < 200; k++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      bb = rs ? ~rb : rb;
      full = {1'b0, ra} + {1'b0, bb} + {{W{1'b0}}, (rs ? 1'b1 : rc)};
      rov = (ra[W-1] == bb[W-1]) && (full[W-1] != ra[W-1]);
      run_op(ra, rb, rc, rs, -1, lat);
      n_cmp++;
      if (lat != W + 1 || {c_out, sum} !== full || ofl !== rov) begin
        n_bad++;
        $display("FAIL ERRORCHECK rand%0d a=%h b=%h cin=%b sub=%b: got lat=%0d {co,sum}=%h ofl=%b want lat=%0d %h ofl=%b",
                 k, ra, rb, rc, rs, lat, {c_out, sum}, ofl, W + 1, full, rov);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
